next_state_sequencer: RTL and testbench

NEXT_STATE_SEQUENCER -- requirements
Module: next_state_sequencer

---
 rtl/mseq_pkg.sv | 46 ++++
 rtl/next_state_sequencer_return_stack.sv | 61 ++++++
 rtl/next_state_sequencer.sv | 178 +++++++++++++++++
 tb/tb_next_state_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mseq_pkg.sv
// Shared types and constants for the microcode next-state sequencer:
// next-state actions, condition selects, fixed states and the opcode decode table.
package mseq_pkg;

    typedef enum logic [2:0] {
        NS_ENCODE = 3'b000,
        NS_FETCH  = 3'b001,
        NS_INCR   = 3'b010,
        NS_JUMP   = 3'b011,
        NS_CJUMP  = 3'b100,
        NS_WAIT   = 3'b101,
        NS_CALL   = 3'b110,
        NS_RETURN = 3'b111
    } ns_sel_e;

    typedef enum logic [1:0] {
        CS_TRUE = 2'b00,
        CS_Z    = 2'b01,
        CS_N    = 2'b10,
        CS_C    = 2'b11
    } cond_sel_e;

    localparam logic [9:0] FETCH_STATE = 10'h001;
    localparam logic [9:0] ERROR_STATE = 10'h3FF;

    // Bit 10 marks a mapped opcode; bits 9:0 hold its entry state.
    localparam logic [10:0] ENC_TABLE [64] = '{
        1:       {1'b1, 10'h00A},
        2:       {1'b1, 10'h020},
        3:       {1'b1, 10'h030},
        16:      {1'b1, 10'h100},
        63:      {1'b1, 10'h200},
        default: {1'b0, 10'h000}
    };

    function automatic logic [9:0] enc_lookup(input logic [5:0] op);
        logic [10:0] entry;
        entry = ENC_TABLE[op];
        if (entry[10]) begin
            enc_lookup = entry[9:0];
        end else begin
            enc_lookup = FETCH_STATE;
        end
    endfunction

endpackage

// File: rtl/next_state_sequencer_return_stack.sv
// LIFO of microcode return addresses; push/pop are ignored when full/empty.
module return_stack
    import mseq_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top_data,
    output logic              full,
    output logic              empty,
    output logic [2:0]        level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [2:0]        level_q;
    logic [2:0]        level_d;
    logic [PTR_W-1:0]  wr_ptr_s;
    logic [PTR_W-1:0]  rd_ptr_s;

    assign wr_ptr_s = PTR_W'(level_q);
    assign rd_ptr_s = PTR_W'(level_q - 3'd1);
    assign full     = (level_q == 3'(DEPTH));
    assign empty    = (level_q == 3'd0);
    assign top_data = mem_q[rd_ptr_s];
    assign level    = level_q;

    // Occupancy update from guarded push/pop requests.
    always_comb begin
        level_d = level_q;
        if (push && !full) begin
            level_d = level_q + 3'd1;
        end else if (pop && !empty) begin
            level_d = level_q - 3'd1;
        end else begin
            level_d = level_q;
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            if (push && !full) begin
                mem_q[wr_ptr_s] <= push_data;
            end
        end
    end

endmodule

// File: rtl/next_state_sequencer.sv
// Microcode next-state sequencer with return stack.
// Define MOC_TIMEOUT_EN to add the memory-operation-complete wait watchdog.
module next_state_sequencer
    import mseq_pkg::*;
#(
    parameter int STATE_W     = 10,
    parameter int STACK_DEPTH = 4,
    parameter int MOC_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         ns_sel,
    input  logic [STATE_W-1:0] cr,
    input  logic               inv,
    input  logic [1:0]         cond_sel,
    input  logic [5:0]         ir_op,
    input  logic               moc,
    input  logic               flag_z,
    input  logic               flag_n,
    input  logic               flag_c,
    output logic [STATE_W-1:0] next_state,
    output logic               bus_error,
    output logic               stack_err,
    output logic [2:0]         stack_level
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [STATE_W-1:0] inc_s;
    logic [STATE_W-1:0] err_state_s;
    logic               sel_cond_s;
    logic               cond_s;
    logic               timeout_s;
    logic               stack_err_q;
    logic               stack_err_d;
    logic               push_s;
    logic               pop_s;
    logic               stk_full_s;
    logic               stk_empty_s;
    logic [STATE_W-1:0] stk_top_s;

    assign inc_s       = state_q + STATE_W'(1);
    assign err_state_s = STATE_W'(ERROR_STATE);

    // Condition multiplexer.
    always_comb begin
        sel_cond_s = 1'b0;
        case (cond_sel_e'(cond_sel))
            CS_TRUE: sel_cond_s = 1'b1;
            CS_Z:    sel_cond_s = flag_z;
            CS_N:    sel_cond_s = flag_n;
            CS_C:    sel_cond_s = flag_c;
            default: sel_cond_s = 1'b0;
        endcase
    end

    assign cond_s = sel_cond_s ^ inv;

    // Next-state selection and stack requests for the current control word.
    always_comb begin
        state_d     = state_q;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        stack_err_d = stack_err_q;
        case (ns_sel_e'(ns_sel))
            NS_ENCODE: state_d = STATE_W'(enc_lookup(ir_op));
            NS_FETCH:  state_d = STATE_W'(FETCH_STATE);
            NS_INCR:   state_d = inc_s;
            NS_JUMP:   state_d = cr;
            NS_CJUMP: begin
                if (cond_s) begin
                    state_d = cr;
                end else begin
                    state_d = inc_s;
                end
            end
            NS_WAIT: begin
                // moc takes priority over a watchdog expiry in the same cycle.
                if (moc) begin
                    state_d = inc_s;
                end else if (timeout_s) begin
                    state_d = err_state_s;
                end else begin
                    state_d = state_q;
                end
            end
            NS_CALL: begin
                if (stk_full_s) begin
                    state_d     = err_state_s;
                    stack_err_d = 1'b1;
                end else begin
                    push_s  = 1'b1;
                    state_d = cr;
                end
            end
            NS_RETURN: begin
                if (stk_empty_s) begin
                    state_d     = err_state_s;
                    stack_err_d = 1'b1;
                end else begin
                    pop_s   = 1'b1;
                    state_d = stk_top_s;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // State address and sticky stack error registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= '0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stack_err_q <= stack_err_d;
        end
    end

`ifdef MOC_TIMEOUT_EN
    localparam int CNT_W = $clog2(MOC_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             bus_error_q;
    logic             bus_error_d;
    logic             waiting_s;

    assign waiting_s = (ns_sel == NS_WAIT) && !moc;
    assign timeout_s = waiting_s && (wait_cnt_q == CNT_W'(MOC_TIMEOUT - 1));

    // Wait counter advances only while stalled; expiry restarts it.
    always_comb begin
        wait_cnt_d  = '0;
        bus_error_d = bus_error_q | timeout_s;
        if (waiting_s && !timeout_s) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_d = '0;
        end
    end

    // Watchdog counter and sticky bus error registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign bus_error = bus_error_q;
`else
    assign timeout_s = 1'b0;
    assign bus_error = 1'b0;
`endif

    return_stack #(
        .DATA_W (STATE_W),
        .DEPTH  (STACK_DEPTH)
    ) u_return_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (inc_s),
        .top_data  (stk_top_s),
        .full      (stk_full_s),
        .empty     (stk_empty_s),
        .level     (stack_level)
    );

    assign next_state = state_q;
    assign stack_err  = stack_err_q;

endmodule

// File: tb/tb_next_state_sequencer.sv
// Directed scoreboard bench for next_state_sequencer against a behavioural reference model.
module tb_next_state_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] ns_sel = 3'd0;
    logic [9:0] cr = 10'd0;
    logic       inv = 1'b0;
    logic [1:0] cond_sel = 2'd0;
    logic [5:0] ir_op = 6'd0;
    logic       moc = 1'b0;
    logic       flag_z = 1'b0;
    logic       flag_n = 1'b0;
    logic       flag_c = 1'b0;
    logic [9:0] next_state;
    logic       bus_error;
    logic       stack_err;
    logic [2:0] stack_level;

    next_state_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ns_sel      (ns_sel),
        .cr          (cr),
        .inv         (inv),
        .cond_sel    (cond_sel),
        .ir_op       (ir_op),
        .moc         (moc),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_c      (flag_c),
        .next_state  (next_state),
        .bus_error   (bus_error),
        .stack_err   (stack_err),
        .stack_level (stack_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] ns;
        logic [2:0] lvl;
        logic       serr;
        logic       berr;
    } obs_t;

`ifdef MOC_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO = 255;

    obs_t       sb[$];
    int         n_tests = 0;
    int         n_fail = 0;
    logic [9:0] m_ns;
    logic [9:0] m_stk[$];
    logic       m_serr;
    logic       m_berr;
    int         m_cnt;

    function automatic logic [9:0] tb_enc(input logic [5:0] op);
        case (op)
            6'd1:    return 10'h00A;
            6'd2:    return 10'h020;
            6'd3:    return 10'h030;
            6'd16:   return 10'h100;
            6'd63:   return 10'h200;
            default: return 10'h001;
        endcase
    endfunction

    function automatic obs_t dut_obs();
        return '{ns: next_state, lvl: stack_level, serr: stack_err, berr: bus_error};
    endfunction

    task automatic check(input string tag, input obs_t exp);
        obs_t got;
        got = dut_obs();
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed ns=%h lvl=%0d serr=%b berr=%b expected ns=%h lvl=%0d serr=%b berr=%b",
                   tag, got.ns, got.lvl, got.serr, got.berr, exp.ns, exp.lvl, exp.serr, exp.berr);
        end
    endtask

    function automatic obs_t model_obs();
        return '{ns: m_ns, lvl: 3'(m_stk.size()), serr: m_serr, berr: m_berr};
    endfunction

    task automatic model_reset();
        m_ns = 10'd0;
        m_stk.delete();
        m_serr = 1'b0;
        m_berr = 1'b0;
        m_cnt = 0;
    endtask

    // Assert reset between edges and check outputs clear with no clock edge.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        model_reset();
        sb.push_back(model_obs());
        #1;
        check(tag, sb.pop_front());
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic step(input string tag, input logic [2:0] ns, input logic [9:0] c, input logic m);
        logic [9:0] inc;
        logic       cnd;
        logic       tmo;
        ns_sel = ns;
        cr = c;
        moc = m;
        inc = m_ns + 10'd1;
        case (cond_sel)
            2'd0:    cnd = 1'b1;
            2'd1:    cnd = flag_z;
            2'd2:    cnd = flag_n;
            default: cnd = flag_c;
        endcase
        cnd = cnd ^ inv;
        tmo = TMO_EN && (ns == 3'd5) && !m && (m_cnt == TMO - 1);
        case (ns)
            3'd0: m_ns = tb_enc(ir_op);
            3'd1: m_ns = 10'h001;
            3'd2: m_ns = inc;
            3'd3: m_ns = c;
            3'd4: m_ns = cnd ? c : inc;
            3'd5: begin
                if (m) m_ns = inc;
                else if (tmo) begin
                    m_ns = 10'h3FF;
                    m_berr = 1'b1;
                end
            end
            3'd6: begin
                if (m_stk.size() == 4) begin
                    m_ns = 10'h3FF;
                    m_serr = 1'b1;
                end else begin
                    m_stk.push_back(inc);
                    m_ns = c;
                end
            end
            default: begin
                if (m_stk.size() == 0) begin
                    m_ns = 10'h3FF;
                    m_serr = 1'b1;
                end else begin
                    m_ns = m_stk.pop_back();
                end
            end
        endcase
        if (TMO_EN && ns == 3'd5 && !m && !tmo) m_cnt++;
        else m_cnt = 0;
        sb.push_back(model_obs());
        @(posedge clk);
        #1;
        check(tag, sb.pop_front());
    endtask

    initial begin
        #2_000_000;
        $fatal(1, "FAIL watchdog: observed timeout expected completion");
    end

    initial begin
        @(negedge clk);
        do_reset("reset_init");

        step("incr1", 3'd2, 10'd0, 1'b0);
        check("incr1_lit", '{ns: 10'd1, lvl: 3'd0, serr: 1'b0, berr: 1'b0});
        step("incr2", 3'd2, 10'd0, 1'b0);
        step("incr3", 3'd2, 10'd0, 1'b0);
        check("incr3_lit", '{ns: 10'd3, lvl: 3'd0, serr: 1'b0, berr: 1'b0});

        step("jump7", 3'd3, 10'd7, 1'b0);
        cond_sel = 2'd1; flag_z = 1'b1; inv = 1'b1;
        step("cjump_inv_z", 3'd4, 10'd20, 1'b0);
        check("cjump_inv_z_lit", '{ns: 10'd8, lvl: 3'd0, serr: 1'b0, berr: 1'b0});
        inv = 1'b0;
        step("cjump_z", 3'd4, 10'd20, 1'b0);
        cond_sel = 2'd2; flag_n = 1'b0; inv = 1'b1;
        step("cjump_inv_n", 3'd4, 10'd25, 1'b0);
        cond_sel = 2'd3; flag_c = 1'b1; inv = 1'b0;
        step("cjump_c", 3'd4, 10'd30, 1'b0);
        cond_sel = 2'd0; inv = 1'b1;
        step("cjump_false", 3'd4, 10'd50, 1'b0);
        inv = 1'b0; flag_z = 1'b0; flag_c = 1'b0;

        ir_op = 6'd1;
        step("enc_mapped", 3'd0, 10'd0, 1'b0);
        check("enc_mapped_lit", '{ns: 10'd10, lvl: 3'd0, serr: 1'b0, berr: 1'b0});
        ir_op = 6'd63;
        step("enc_63", 3'd0, 10'd0, 1'b0);
        ir_op = 6'd5;
        step("enc_unmapped", 3'd0, 10'd0, 1'b0);
        check("enc_unmapped_lit", '{ns: 10'd1, lvl: 3'd0, serr: 1'b0, berr: 1'b0});
        step("jump_max", 3'd3, 10'h3FF, 1'b0);
        step("incr_wrap", 3'd2, 10'd0, 1'b0);
        step("jump_9", 3'd3, 10'd9, 1'b0);
        step("fetch", 3'd1, 10'd0, 1'b0);

        for (int i = 0; i < 5; i++) step("call", 3'd6, 10'd40, 1'b0);
        check("call_overflow_lit", '{ns: 10'h3FF, lvl: 3'd4, serr: 1'b1, berr: 1'b0});
        for (int i = 0; i < 4; i++) step("return", 3'd7, 10'd0, 1'b0);
        step("return_empty", 3'd7, 10'd0, 1'b0);

        do_reset("reset_stack");
        step("ret_empty_fresh", 3'd7, 10'd0, 1'b0);
        check("ret_empty_lit", '{ns: 10'h3FF, lvl: 3'd0, serr: 1'b1, berr: 1'b0});
        step("err_sticky", 3'd1, 10'd0, 1'b0);

        do_reset("reset_wait1");
        step("jump2", 3'd3, 10'd2, 1'b0);
        for (int i = 0; i < TMO; i++) step("wait_stall", 3'd5, 10'd0, 1'b0);
        if (TMO_EN) check("wait_timeout_lit", '{ns: 10'h3FF, lvl: 3'd0, serr: 1'b0, berr: 1'b1});
        else        check("wait_hold_lit", '{ns: 10'd2, lvl: 3'd0, serr: 1'b0, berr: 1'b0});
        step("berr_sticky", 3'd1, 10'd0, 1'b0);

        do_reset("reset_wait2");
        step("jump2b", 3'd3, 10'd2, 1'b0);
        for (int i = 0; i < TMO - 1; i++) step("wait_stall2", 3'd5, 10'd0, 1'b0);
        step("wait_moc_last", 3'd5, 10'd0, 1'b1);
        check("wait_moc_lit", '{ns: 10'd3, lvl: 3'd0, serr: 1'b0, berr: 1'b0});
        for (int i = 0; i < 100; i++) step("wait_stall3", 3'd5, 10'd0, 1'b0);
        step("wait_break", 3'd2, 10'd0, 1'b0);
        for (int i = 0; i < TMO - 1; i++) step("wait_stall4", 3'd5, 10'd0, 1'b0);
        step("wait_moc_end", 3'd5, 10'd0, 1'b1);

        do_reset("reset_call");
        step("call_a", 3'd6, 10'd40, 1'b0);
        step("call_b", 3'd6, 10'd40, 1'b0);
        for (int i = 0; i < 5; i++) step("wait_mid", 3'd5, 10'd0, 1'b0);
        check("pre_reset_lit", '{ns: 10'd40, lvl: 3'd2, serr: 1'b0, berr: 1'b0});
        #2;
        do_reset("reset_mid_wait");
        step("post_reset_incr", 3'd2, 10'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
